// File: rtl/decode_dispatch_ctrl.sv
// Fetch-to-decode instruction buffer with per-exu dispatch handshakes and halt-on-illegal.
// Define SFO_EN to enable short-forward-branch shadow tracking (SHADOW state, under_shadow outputs).
module decode_dispatch_ctrl #(
  parameter int DEPTH      = 4,
  parameter int SHADOW_MAX = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        fetch_valid,
  input  logic [31:0] fetch_instr,
  input  logic [31:0] fetch_pc,
  output logic        fetch_ready,
  output logic [31:0] dec_instr,
  output logic [31:0] dec_pc,
  output logic        dec_under_shadow,
  input  logic        dec_legal,
  input  logic [1:0]  dec_exu,
  input  logic        dec_is_branch,
  input  logic        dec_shadowable,
  input  logic [31:0] dec_btarget,
  output logic [3:0]  disp_valid,
  input  logic [3:0]  disp_ready,
  output logic [31:0] disp_instr,
  output logic [31:0] disp_pc,
  output logic        disp_shadowed,
  output logic        illegal,
  output logic [31:0] illegal_pc
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

`ifdef SFO_EN
  typedef enum logic [1:0] {RUN, SHADOW, HALT} state_t;
`else
  typedef enum logic {RUN, HALT} state_t;
`endif

  state_t          state, state_n;
  logic [31:0]     buf_instr [DEPTH];
  logic [31:0]     buf_pc    [DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic            not_empty, push, fire, head_illegal;

  assign not_empty    = (count != '0);
  assign fetch_ready  = (count < CW'(DEPTH)) & ~flush;
  assign push         = fetch_valid & fetch_ready;
  assign fire         = |(disp_valid & disp_ready);
  assign head_illegal = not_empty & ~dec_legal & (state != HALT);

  assign dec_instr  = not_empty ? buf_instr[rd_ptr] : '0;
  assign dec_pc     = not_empty ? buf_pc[rd_ptr]    : '0;
  assign disp_instr = dec_instr;
  assign disp_pc    = dec_pc;

  always_comb begin
    disp_valid = '0;
    if (not_empty & dec_legal & (state != HALT))
      disp_valid[dec_exu] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      buf_instr[wr_ptr] <= fetch_instr;
      buf_pc[wr_ptr]    <= fetch_pc;
    end
  end

  // Flush discards any fetch or dispatch handshake of its own cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= RUN;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      illegal    <= 1'b0;
      illegal_pc <= '0;
    end else if (flush) begin
      state   <= RUN;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      illegal <= 1'b0;
    end else begin
      state <= state_n;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (fire) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(fire);
      if (head_illegal) begin
        illegal    <= 1'b1;
        illegal_pc <= dec_pc;
      end
    end
  end

`ifdef SFO_EN
  localparam int RW = $clog2(SHADOW_MAX + 1);

  logic [RW-1:0] rem, rem_n;
  logic [31:0]   target, target_n, dist;
  logic          opens, under;

  assign dist  = (dec_btarget - dec_pc) >> 2;
  assign opens = dec_is_branch & (dec_btarget > dec_pc) &
                 (dist >= 32'd2) & (dist <= 32'(SHADOW_MAX));
  assign under = (state == SHADOW) & not_empty & (dec_pc != target);

  assign dec_under_shadow = under;
  assign disp_shadowed    = dec_shadowable & under;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rem    <= '0;
      target <= '0;
    end else begin
      rem    <= rem_n;
      target <= target_n;
    end
  end

  always_comb begin
    state_n  = state;
    rem_n    = rem;
    target_n = target;
    case (state)
      RUN: begin
        if (head_illegal) state_n = HALT;
        else if (fire & opens) begin
          state_n  = SHADOW;
          rem_n    = RW'(dist - 32'd1);
          target_n = dec_btarget;
        end
      end
      SHADOW: begin
        if (head_illegal) state_n = HALT;
        else begin
          if (not_empty & ~under) state_n = RUN;
          else if (fire) begin
            if (~dec_shadowable | dec_is_branch) state_n = RUN;
            else begin
              rem_n = rem - 1'b1;
              if (rem == RW'(1)) state_n = RUN;
            end
          end
          // A shadow that just closed (target reached or cancelled) may be reopened by this same dispatch.
          if (fire & (state_n == RUN) & opens) begin
            state_n  = SHADOW;
            rem_n    = RW'(dist - 32'd1);
            target_n = dec_btarget;
          end
        end
      end
      HALT:    state_n = HALT;
      default: state_n = RUN;
    endcase
  end
`else
  logic unused_sfo;
  assign unused_sfo       = ^{dec_is_branch, dec_shadowable, dec_btarget};
  assign dec_under_shadow = 1'b0;
  assign disp_shadowed    = 1'b0;

  always_comb begin
    state_n = state;
    if (state == RUN && head_illegal) state_n = HALT;
  end
`endif

endmodule

// File: tb/tb_decode_dispatch_ctrl.sv
// Bench for decode_dispatch_ctrl: directed scenarios plus a randomized run against a queue-based model.
// Shadow expectations follow SFO_EN at compile time.
module tb_decode_dispatch_ctrl;
  localparam int DEPTH = 4;
  localparam int SHADOW_MAX = 8;
`ifdef SFO_EN
  localparam bit SFO = 1'b1;
`else
  localparam bit SFO = 1'b0;
`endif

  logic clk = 1'b0, rst = 1'b0, flush = 1'b0;
  logic fetch_valid = 1'b0, fetch_ready;
  logic [31:0] fetch_instr = '0, fetch_pc = '0;
  logic [31:0] dec_instr, dec_pc, dec_btarget = '0;
  logic dec_under_shadow, dec_legal = 1'b0, dec_is_branch = 1'b0, dec_shadowable = 1'b0;
  logic [1:0] dec_exu = '0;
  logic [3:0] disp_valid, disp_ready = '0;
  logic [31:0] disp_instr, disp_pc, illegal_pc;
  logic disp_shadowed, illegal;

  int checks = 0, errors = 0;

  decode_dispatch_ctrl #(.DEPTH(DEPTH), .SHADOW_MAX(SHADOW_MAX)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .fetch_valid(fetch_valid), .fetch_instr(fetch_instr), .fetch_pc(fetch_pc), .fetch_ready(fetch_ready),
    .dec_instr(dec_instr), .dec_pc(dec_pc), .dec_under_shadow(dec_under_shadow),
    .dec_legal(dec_legal), .dec_exu(dec_exu), .dec_is_branch(dec_is_branch),
    .dec_shadowable(dec_shadowable), .dec_btarget(dec_btarget),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_instr(disp_instr), .disp_pc(disp_pc),
    .disp_shadowed(disp_shadowed), .illegal(illegal), .illegal_pc(illegal_pc)
  );

  always #5 clk = ~clk;

  // Directed instruction sequence with its decode attributes.
  logic [31:0] s_instr [4], s_pc [4], s_tgt [4];
  logic [1:0]  s_exu [4];
  bit          s_legal [4], s_br [4], s_sh [4];

  task automatic set_seq(input int i, input logic [31:0] ins, input logic [31:0] pc, input logic [1:0] exu,
                         input bit legal, input bit br, input bit sh, input logic [31:0] tgt);
    s_instr[i] = ins; s_pc[i] = pc; s_exu[i] = exu; s_legal[i] = legal; s_br[i] = br; s_sh[i] = sh; s_tgt[i] = tgt;
  endtask

  task automatic drive_head(input int i);
    dec_legal = s_legal[i]; dec_exu = s_exu[i]; dec_is_branch = s_br[i];
    dec_shadowable = s_sh[i]; dec_btarget = s_tgt[i];
  endtask

  task automatic load_seq(input int n);
    disp_ready = '0;
    for (int i = 0; i < n; i++) begin
      fetch_valid = 1'b1; fetch_instr = s_instr[i]; fetch_pc = s_pc[i];
      drive_head(0);
      @(negedge clk);
    end
    fetch_valid = 1'b0;
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] instr, pc, tgt;
    bit legal, br, sh;
    logic [1:0] exu;
  } ent_t;
  ent_t q[$];
  ent_t offer;
  bit m_open, m_halt, m_ill;
  int m_rem;
  logic [31:0] m_tgt, m_ill_pc;
  logic e_fready, e_under, e_shadowed;
  logic [31:0] e_instr, e_pc;
  logic [3:0] e_valid;

  function automatic void model_reset();
    q.delete(); m_open = 0; m_halt = 0; m_ill = 0; m_rem = 0; m_tgt = '0; m_ill_pc = '0;
  endfunction

  function automatic void model_expect();
    bit ne = (q.size() > 0);
    e_fready   = (q.size() < DEPTH) && !flush;
    e_instr    = ne ? q[0].instr : 32'h0;
    e_pc       = ne ? q[0].pc : 32'h0;
    e_under    = SFO && m_open && ne && (q[0].pc != m_tgt);
    e_valid    = (ne && q[0].legal && !m_halt) ? (4'b0001 << q[0].exu) : 4'b0000;
    e_shadowed = ne && q[0].sh && e_under;
  endfunction

  function automatic void model_edge();
    bit ne, fire, push;
    logic [31:0] d;
    ent_t h;
    if (flush) begin
      q.delete(); m_open = 0; m_halt = 0; m_ill = 0;
      return;
    end
    ne   = (q.size() > 0);
    fire = ((e_valid & disp_ready) != 4'b0000);
    push = fetch_valid && e_fready;
    if (ne && !q[0].legal && !m_halt) begin
      m_halt = 1; m_ill = 1; m_ill_pc = q[0].pc; m_open = 0;
    end else if (ne && !m_halt && SFO) begin
      h = q[0];
      if (m_open && h.pc == m_tgt) m_open = 0;
      if (fire) begin
        if (m_open) begin
          if (!h.sh || h.br) m_open = 0;
          else begin
            m_rem--;
            if (m_rem == 0) m_open = 0;
          end
        end
        if (!m_open && h.br && h.tgt > h.pc) begin
          d = (h.tgt - h.pc) >> 2;
          if (d >= 2 && d <= SHADOW_MAX) begin
            m_open = 1; m_rem = int'(d) - 1; m_tgt = h.tgt;
          end
        end
      end
    end
    if (fire) void'(q.pop_front());
    if (push) q.push_back(offer);
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b0;
    #1;
    checks++; if (fetch_ready !== 1'b1) begin errors++; $display("FAIL reset_fetch_ready: got %b want 1", fetch_ready); end
    checks++; if (disp_valid !== 4'b0000) begin errors++; $display("FAIL reset_disp_valid: got %b want 0000", disp_valid); end
    checks++; if (illegal !== 1'b0 || illegal_pc !== 32'h0) begin errors++; $display("FAIL reset_illegal: got %b/%h want 0/0", illegal, illegal_pc); end
    checks++; if (dec_under_shadow !== 1'b0) begin errors++; $display("FAIL reset_under_shadow: got %b want 0", dec_under_shadow); end
    checks++; if (dec_instr !== 32'h0 || dec_pc !== 32'h0) begin errors++; $display("FAIL reset_head: got %h/%h want 0/0", dec_instr, dec_pc); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_single();
    set_seq(0, 32'h00500093, 32'h100, 2'd0, 1, 0, 1, 32'h0);
    fetch_valid = 1'b1; fetch_instr = s_instr[0]; fetch_pc = s_pc[0]; disp_ready = 4'b1111; drive_head(0);
    #1;
    checks++; if (disp_valid !== 4'b0000) begin errors++; $display("FAIL single_no_bypass: got %b want 0000", disp_valid); end
    @(negedge clk);
    fetch_valid = 1'b0;
    #1;
    checks++; if (disp_valid !== 4'b0001) begin errors++; $display("FAIL single_disp_valid: got %b want 0001", disp_valid); end
    checks++; if (disp_pc !== 32'h100 || disp_instr !== 32'h00500093) begin errors++; $display("FAIL single_disp_data: got %h/%h want 100/00500093", disp_pc, disp_instr); end
    @(negedge clk);
    #1;
    checks++; if (dec_pc !== 32'h0 || disp_valid !== 4'b0000) begin errors++; $display("FAIL single_empty: got pc %h valid %b want 0/0000", dec_pc, disp_valid); end
    @(negedge clk);
  endtask

  task automatic test_fill();
    for (int i = 0; i < 4; i++) set_seq(i, 32'h0000a003 + i, 32'h500 + 32'(4 * i), 2'd2, 1, 0, 1, 32'h0);
    load_seq(4);
    #1;
    checks++; if (fetch_ready !== 1'b0) begin errors++; $display("FAIL fill_full: got %b want 0", fetch_ready); end
    checks++; if (disp_valid !== 4'b0100) begin errors++; $display("FAIL fill_waiting: got %b want 0100", disp_valid); end
    disp_ready = 4'b1011;
    @(negedge clk);
    #1;
    checks++; if (dec_pc !== 32'h500) begin errors++; $display("FAIL fill_unselected_ready: got %h want 500", dec_pc); end
    // Offer a fifth instruction while popping at full: must not be accepted.
    disp_ready = 4'b0100; fetch_valid = 1'b1; fetch_instr = 32'hdeadbeef; fetch_pc = 32'h510;
    #1;
    checks++; if (fetch_ready !== 1'b0) begin errors++; $display("FAIL fill_no_full_bypass: got %b want 0", fetch_ready); end
    @(negedge clk);
    fetch_valid = 1'b0;
    for (int i = 1; i < 4; i++) begin
      drive_head(i);
      #1;
      checks++; if (dec_pc !== s_pc[i] || disp_valid !== 4'b0100) begin errors++; $display("FAIL fill_drain%0d: got %h/%b want %h/0100", i, dec_pc, disp_valid, s_pc[i]); end
      checks++; if (fetch_ready !== 1'b1) begin errors++; $display("FAIL fill_ready%0d: got %b want 1", i, fetch_ready); end
      @(negedge clk);
    end
    #1;
    checks++; if (dec_pc !== 32'h0) begin errors++; $display("FAIL fill_empty: got %h want 0", dec_pc); end
    disp_ready = '0;
    @(negedge clk);
  endtask

  task automatic drain_shadow(input string name, input bit exp_un [4], input bit exp_sh [4]);
    disp_ready = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      drive_head(i);
      #1;
      checks++; if (disp_pc !== s_pc[i] || disp_valid !== (4'b0001 << s_exu[i])) begin errors++; $display("FAIL %s_dispatch%0d: got %h/%b want %h/%b", name, i, disp_pc, disp_valid, s_pc[i], 4'b0001 << s_exu[i]); end
      checks++; if (dec_under_shadow !== exp_un[i]) begin errors++; $display("FAIL %s_under%0d: got %b want %b", name, i, dec_under_shadow, exp_un[i]); end
      checks++; if (disp_shadowed !== exp_sh[i]) begin errors++; $display("FAIL %s_shadowed%0d: got %b want %b", name, i, disp_shadowed, exp_sh[i]); end
      @(negedge clk);
    end
    disp_ready = '0;
  endtask

  task automatic test_shadow();
    bit un [4], sh [4];
    set_seq(0, 32'h00000663, 32'h200, 2'd1, 1, 1, 0, 32'h20c);
    set_seq(1, 32'h00100093, 32'h204, 2'd0, 1, 0, 1, 32'h0);
    set_seq(2, 32'h0010c093, 32'h208, 2'd0, 1, 0, 1, 32'h0);
    set_seq(3, 32'h00200093, 32'h20c, 2'd0, 1, 0, 1, 32'h0);
    un = '{0, SFO, SFO, 0}; sh = '{0, SFO, SFO, 0};
    load_seq(4);
    drain_shadow("shadow", un, sh);
  endtask

  task automatic test_cancel();
    bit un [4], sh [4];
    set_seq(0, 32'h00000863, 32'h300, 2'd1, 1, 1, 0, 32'h310);
    set_seq(1, 32'h00112023, 32'h304, 2'd2, 1, 0, 0, 32'h0);
    set_seq(2, 32'h00100093, 32'h308, 2'd0, 1, 0, 1, 32'h0);
    set_seq(3, 32'h00200093, 32'h30c, 2'd0, 1, 0, 1, 32'h0);
    un = '{0, SFO, 0, 0}; sh = '{0, 0, 0, 0};
    load_seq(4);
    drain_shadow("cancel", un, sh);
  endtask

  task automatic test_illegal();
    set_seq(0, 32'h02208033, 32'h400, 2'd3, 0, 0, 1, 32'h0);
    set_seq(1, 32'h00100093, 32'h404, 2'd0, 1, 0, 1, 32'h0);
    load_seq(2);
    disp_ready = 4'b1111; drive_head(0);
    #1;
    checks++; if (disp_valid !== 4'b0000) begin errors++; $display("FAIL illegal_no_dispatch: got %b want 0000", disp_valid); end
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      #1;
      checks++; if (illegal !== 1'b1 || illegal_pc !== 32'h400) begin errors++; $display("FAIL illegal_flag%0d: got %b/%h want 1/400", k, illegal, illegal_pc); end
      checks++; if (disp_valid !== 4'b0000 || dec_pc !== 32'h400) begin errors++; $display("FAIL illegal_halt%0d: got %b/%h want 0000/400", k, disp_valid, dec_pc); end
      @(negedge clk);
    end
    flush = 1'b1; fetch_valid = 1'b1; fetch_pc = 32'h408;
    #1;
    checks++; if (fetch_ready !== 1'b0) begin errors++; $display("FAIL flush_fetch_ready: got %b want 0", fetch_ready); end
    @(negedge clk);
    flush = 1'b0; fetch_valid = 1'b0;
    #1;
    checks++; if (illegal !== 1'b0 || dec_pc !== 32'h0 || fetch_ready !== 1'b1) begin errors++; $display("FAIL flush_clear: got %b/%h/%b want 0/0/1", illegal, dec_pc, fetch_ready); end
    disp_ready = '0;
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    set_seq(0, 32'h0080006f, 32'h600, 2'd1, 1, 0, 0, 32'h0);
    load_seq(1);
    drive_head(0);
    #1;
    checks++; if (disp_valid !== 4'b0010) begin errors++; $display("FAIL areset_waiting: got %b want 0010", disp_valid); end
    #2 rst = 1'b0;
    #1;
    checks++; if (disp_valid !== 4'b0000 || fetch_ready !== 1'b1 || dec_pc !== 32'h0) begin errors++; $display("FAIL areset_immediate: got %b/%b/%h want 0000/1/0", disp_valid, fetch_ready, dec_pc); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_random();
    logic [31:0] next_pc;
    rst = 1'b0; model_reset();
    @(negedge clk);
    rst = 1'b1;
    next_pc = 32'h1000;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      offer.pc = next_pc; offer.instr = $urandom; offer.exu = 2'($urandom_range(0, 3));
      offer.legal = ($urandom_range(0, 39) != 0); offer.br = ($urandom_range(0, 3) == 0);
      offer.sh = offer.br ? 1'b0 : ($urandom_range(0, 3) != 0);
      offer.tgt = ($urandom_range(0, 4) == 0) ? next_pc - 32'(4 * $urandom_range(1, 8))
                                              : next_pc + 32'(4 * $urandom_range(0, 11));
      fetch_valid = ($urandom_range(0, 2) != 0); fetch_instr = offer.instr; fetch_pc = offer.pc;
      disp_ready = 4'($urandom);
      flush = m_halt ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 79) == 0);
      if (q.size() > 0) begin
        dec_legal = q[0].legal; dec_exu = q[0].exu; dec_is_branch = q[0].br;
        dec_shadowable = q[0].sh; dec_btarget = q[0].tgt;
      end else begin
        dec_legal = 1'($urandom); dec_exu = 2'($urandom); dec_is_branch = 1'($urandom);
        dec_shadowable = 1'($urandom); dec_btarget = $urandom;
      end
      #1;
      model_expect();
      checks++; if (fetch_ready !== e_fready) begin errors++; $display("FAIL rnd_fetch_ready @%0d: got %b want %b", cyc, fetch_ready, e_fready); end
      checks++; if (dec_instr !== e_instr || disp_instr !== e_instr) begin errors++; $display("FAIL rnd_instr @%0d: got %h/%h want %h", cyc, dec_instr, disp_instr, e_instr); end
      checks++; if (dec_pc !== e_pc || disp_pc !== e_pc) begin errors++; $display("FAIL rnd_pc @%0d: got %h/%h want %h", cyc, dec_pc, disp_pc, e_pc); end
      checks++; if (disp_valid !== e_valid) begin errors++; $display("FAIL rnd_disp_valid @%0d: got %b want %b", cyc, disp_valid, e_valid); end
      checks++; if (dec_under_shadow !== e_under) begin errors++; $display("FAIL rnd_under @%0d: got %b want %b", cyc, dec_under_shadow, e_under); end
      checks++; if (disp_shadowed !== e_shadowed) begin errors++; $display("FAIL rnd_shadowed @%0d: got %b want %b", cyc, disp_shadowed, e_shadowed); end
      checks++; if (illegal !== m_ill || illegal_pc !== m_ill_pc) begin errors++; $display("FAIL rnd_illegal @%0d: got %b/%h want %b/%h", cyc, illegal, illegal_pc, m_ill, m_ill_pc); end
      @(posedge clk);
      if (flush) next_pc = 32'h1000 + 32'(4 * $urandom_range(0, 1023));
      else if (fetch_valid && e_fready) next_pc = next_pc + 32'd4;
      model_edge();
      @(negedge clk);
    end
    fetch_valid = 1'b0; flush = 1'b0; disp_ready = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_shadow();
    test_cancel();
    test_illegal();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule

// File: doc/decode_dispatch_ctrl.md
Name: decode_dispatch_ctrl

Overview:
- Sequencing controller between fetch and the decode unit.
- Buffers fetched instructions in a small FIFO and presents the head to the decode unit combinationally.
- Dispatches the decoded head to the execution unit the decoder selects (alu/jmp/mem/mul), using valid/ready handshakes.
- Tracks short-forward-branch (SFO) shadows and drives under_shadow into decode; halts on illegal instructions until flush.

Parameters:
DEPTH, 4, instruction buffer entries; power of 2, minimum 2
SHADOW_MAX, 8, maximum forward branch distance in instructions that opens a shadow

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
flush  in  1  synchronous pipeline flush
fetch_valid  in  1  fetch offers an instruction
fetch_instr  in  32  instruction word
fetch_pc  in  32  PC of fetch_instr
fetch_ready  out  1  buffer can accept
dec_instr  out  32  buffer head, to decode unit
dec_pc  out  32  PC of head
dec_under_shadow  out  1  head lies inside an open SFO shadow
dec_legal  in  1  decode ctrl.legal
dec_exu  in  2  decode ctrl.exu: 0 alu, 1 jmp, 2 mem, 3 mul
dec_is_branch  in  1  decode bctrl conditional-branch flag
dec_shadowable  in  1  decode bctrl.shadowable
dec_btarget  in  32  branch target for the head
disp_valid  out  4  one-hot per exu, indexed by dec_exu
disp_ready  in  4  per-exu ready
disp_instr  out  32  equals dec_instr
disp_pc  out  32  equals dec_pc
disp_shadowed  out  1  equals dec_shadowable & dec_under_shadow
illegal  out  1  sticky illegal-instruction flag
illegal_pc  out  32  PC of the first illegal instruction

Behaviour:
- Reset (rst=0, async): buffer empty; state=RUN; shadow count 0; illegal=0; illegal_pc=0; disp_valid=0; dec_under_shadow=0; fetch_ready=1. dec_instr/dec_pc read 0 while empty.
- Buffer:
  - Push when fetch_valid & fetch_ready.
  - fetch_ready = (count<DEPTH) & !flush. There is no full-bypass: at full, a simultaneous pop does not enable a push that cycle.
  - Pop when any disp_valid[i] & disp_ready[i].
  - Pointers wrap modulo DEPTH.
  - Push and pop in the same cycle leave count unchanged.
- Latency: an instruction pushed at edge t is at the head and may dispatch from cycle t+1. No fetch-to-dispatch bypass.
- Dispatch:
  - disp_valid[dec_exu] = (count>0) & dec_legal & (state!=HALT).
  - All other bits are 0.
  - Head and outputs hold stable until the handshake fires.
  - disp_ready on non-selected units is ignored.
- State RUN:
  - Head illegal (count>0 & !dec_legal): no dispatch; set illegal=1 and illegal_pc=dec_pc; go to HALT.
  - Head is a branch with dec_btarget>dec_pc and d=(dec_btarget-dec_pc)>>2 in 2..SHADOW_MAX, dispatched: go to SHADOW with remaining=d-1 and target=dec_btarget.
  - d<2, d>SHADOW_MAX, or a backward target: no shadow.
- State SHADOW:
  - dec_under_shadow = (count>0) & (dec_pc!=target).
  - Each dispatched shadowed instruction decrements remaining.
  - Return to RUN when remaining reaches 0 on a dispatch, or when dec_pc==target (target instruction not shadowed).
  - Head not shadowable while under shadow: cancel the shadow (go to RUN); that instruction dispatches unshadowed.
  - A nested branch inside a shadow is treated as non-shadowable and cancels the shadow; it may then open a new shadow as in RUN, in the same dispatch.
  - Illegal head: HALT as in RUN.
- State HALT: no dispatch, no pop; pushes continue until the buffer is full.
- flush (synchronous, highest priority):
  - Next cycle: buffer empty, state=RUN, illegal=0, disp_valid=0.
  - Any fetch or dispatch handshake in the flush cycle is discarded. A dispatch fire in that cycle still counts as delivered to the exu.
- Reset asserted mid-handshake: all state is cleared immediately; outputs go to reset values asynchronously.

Optional Feature:
- Macro SFO_EN.
- Defined: SHADOW state and shadow tracking as described.
- Undefined: no SHADOW state; dec_under_shadow and disp_shadowed are tied to 0; branches never open shadows. Buffer, dispatch and HALT behaviour are unchanged.

Test Plan:
- Reset, then push ADDI (exu 0) at pc 0x100 with disp_ready=4'b1111 -> disp_valid=4'b0001 one cycle after push; pop; buffer empty.
- Fill with 4 instructions while disp_ready=0 -> fetch_ready=0 after 4th push; then set disp_ready[2]=1 with head LW -> one pop per cycle and fetch_ready=1 again after the first pop.
- SFO_EN: BEQ at 0x200, target 0x20C, followed by ADDI 0x204 and XORI 0x208 -> both dispatch with disp_shadowed=1; the 0x20C instruction dispatches with disp_shadowed=0; state back in RUN.
- SFO_EN: BEQ 0x300 to 0x310, then SW at 0x304 (not shadowable) -> shadow cancelled; SW and later instructions dispatch with disp_shadowed=0.
- Illegal head (MUL, legal=0) at 0x400 -> disp_valid=0, illegal=1, illegal_pc=0x400 held; flush -> illegal=0 and buffer empty next cycle.
- Assert rst low while disp_valid=4'b0010 is waiting on ready -> disp_valid=0 and fetch_ready=1 immediately, without waiting for a clock edge.
